blit_phase_seq: RTL

Blitter inner-loop phase sequencer. It is the initiator side of the phase-strobe interface that the data-path control consumes (srcdreadd, dwrite, dzwrite, dzwrite1, atick).
- On a GPU command write (cmdld with gpu_din), it latches the read/write enable bits of the blitter command word.
- It then steps through the enabled memory phases for each pixel/phrase, handshaking each phase with the memory interface.
- It counts down the inner count and flags completion.

---
 rtl/blit_phase_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/blit_phase_seq.sv
// Blitter inner-loop phase sequencer: walks the enabled memory phases per pixel,
// handshakes each with the memory interface and counts down the inner loop.
module blit_phase_seq #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             cmdld,
  input  logic [31:0]      gpu_din,
  input  logic             cnt_ld,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic             mem_ack,
  output logic             mem_req,
  output logic             srcxread,
  output logic             srcdread,
  output logic             srczread,
  output logic             dstdread,
  output logic             dstzread,
  output logic             dwrite,
  output logic             dzwrite,
  output logic             dzwrite1,
  output logic             srcdreadd,
  output logic [1:0]       atick,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt_out
);

  localparam int unsigned CMD_W = 6;

  typedef enum logic [3:0] {
    IDLE, SREADX, SREAD, SZREAD, DREAD, DZREAD, DWRITE, DZWRITE, FINISH
  } state_t;

  // cmd bits: [0] SRCEN, [1] SRCENZ, [2] SRCENX, [3] DSTEN, [4] DSTENZ, [5] DSTWRZ
  state_t             state, state_nxt;
  logic [CMD_W-1:0]   cmd, cmd_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               srcdreadd_nxt;
  logic               atick0_nxt;
  logic               unused_din;

  assign unused_din = ^gpu_din[31:CMD_W];

  // Next enabled phase following the given one within an iteration.
  function automatic state_t phase_after(state_t s, logic [CMD_W-1:0] c);
    state_t r;
    r = DWRITE;
    case (s)
      SREADX: r = c[0] ? SREAD : c[1] ? SZREAD : c[3] ? DREAD : c[4] ? DZREAD : DWRITE;
      SREAD:  r = c[1] ? SZREAD : c[3] ? DREAD : c[4] ? DZREAD : DWRITE;
      SZREAD: r = c[3] ? DREAD : c[4] ? DZREAD : DWRITE;
      DREAD:  r = c[4] ? DZREAD : DWRITE;
      default: r = DWRITE;
    endcase
    return r;
  endfunction

  // First phase of any iteration; SREADX is deliberately not part of it.
  function automatic state_t iter_first(logic [CMD_W-1:0] c);
    return phase_after(SREADX, c);
  endfunction

  always_comb begin
    state_nxt     = state;
    cmd_nxt       = cmd;
    cnt_nxt       = cnt_out;
    srcdreadd_nxt = 1'b0;
    atick0_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (cnt_ld) cnt_nxt = cnt_in;
        if (cmdld) begin
          cmd_nxt   = gpu_din[CMD_W-1:0];
          state_nxt = gpu_din[2] ? SREADX : iter_first(gpu_din[CMD_W-1:0]);
        end
      end
      FINISH: state_nxt = IDLE;
      DWRITE: begin
        if (mem_ack) begin
          cnt_nxt    = cnt_out - CNT_W'(1);
          atick0_nxt = 1'b1;
          if (cmd[5])              state_nxt = DZWRITE;
          else if (cnt_nxt == '0)  state_nxt = FINISH;
          else                     state_nxt = iter_first(cmd);
        end
      end
      DZWRITE: begin
        if (mem_ack) state_nxt = (cnt_out == '0) ? FINISH : iter_first(cmd);
      end
      default: begin
        if (mem_ack) begin
          state_nxt     = phase_after(state, cmd);
          srcdreadd_nxt = (state == SREAD);
        end
      end
    endcase
  end

  // Strobes are registered from the next state so they line up with the state register.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cmd       <= '0;
      cnt_out   <= '0;
      mem_req   <= 1'b0;
      srcxread  <= 1'b0;
      srcdread  <= 1'b0;
      srczread  <= 1'b0;
      dstdread  <= 1'b0;
      dstzread  <= 1'b0;
      dwrite    <= 1'b0;
      dzwrite   <= 1'b0;
      dzwrite1  <= 1'b0;
      srcdreadd <= 1'b0;
      atick     <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cmd       <= cmd_nxt;
      cnt_out   <= cnt_nxt;
      mem_req   <= (state_nxt != IDLE) && (state_nxt != FINISH);
      srcxread  <= (state_nxt == SREADX);
      srcdread  <= (state_nxt == SREAD);
      srczread  <= (state_nxt == SZREAD);
      dstdread  <= (state_nxt == DREAD);
      dstzread  <= (state_nxt == DZREAD);
      dwrite    <= (state_nxt == DWRITE);
      dzwrite   <= (state_nxt == DZWRITE);
      dzwrite1  <= dzwrite;
      srcdreadd <= srcdreadd_nxt;
      atick     <= {atick[0], atick0_nxt};
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == FINISH);
    end
  end

endmodule
